// File: rtl/decap_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : decap_result_streamer
//  Purpose  : Unloads the eight 32-bit result words of the decapsulation core
//             by sweeping out_addr, and serializes them MSB-first into a byte
//             stream with a valid/ready handshake. The session key (out_k) is
//             always streamed; the r vector (out_r) follows as a second pass
//             only when DECAP_STREAM_R_EN is defined.
//  Config   : DECAP_STREAM_R_EN (undefined by default: key pass only)
//  Revision : 1.0 - initial release
// ============================================================================
module decap_result_streamer #(
   parameter int WORDS  = 8,
   parameter int AW     = 3,
   parameter int RD_LAT = 1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          dec_valid,
   output logic [AW-1:0] out_addr,
   input  logic [31:0]   out_k,
   input  logic [31:0]   out_r,
   input  logic          s_ready,
   output logic          s_valid,
   output logic [7:0]    s_data,
   output logic          s_last,
   output logic          busy,
   output logic          done
);

`ifdef DECAP_STREAM_R_EN
   localparam logic c_r_en = 1'b1;
`else
   localparam logic c_r_en = 1'b0;
`endif

   localparam logic [AW-1:0] c_last_w    = AW'(WORDS - 1);
   localparam logic [1:0]    c_wait_init = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_CAP  = 3'd3,
      ST_SEND = 3'd4,
      ST_FIN  = 3'd5
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_w;
   logic          r_p;
   logic          r_armed;
   logic [1:0]    r_wait;
   logic [1:0]    r_bcnt;
   logic [31:0]   r_sh;
   logic [AW-1:0] r_addr;
   logic          r_s_valid;
   logic [7:0]    r_s_data;
   logic          r_s_last;
   logic          r_busy;
   logic          r_done;

   logic          w_hs;
   logic          w_last_w;
   logic          w_final_pass;
   logic [31:0]   w_word;

   // Handshake, end-of-vector and source-word selection
   assign w_hs         = r_s_valid & s_ready;
   assign w_last_w     = (r_w == c_last_w);
   assign w_final_pass = ~c_r_en | r_p;
   assign w_word       = (c_r_en & r_p) ? out_r : out_k;

   // Sequencer: trigger arming, address sweep, capture and byte serialization
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_IDLE;
         r_w       <= '0;
         r_p       <= 1'b0;
         r_armed   <= 1'b0;
         r_wait    <= 2'd0;
         r_bcnt    <= 2'd0;
         r_sh      <= 32'd0;
         r_addr    <= '0;
         r_s_valid <= 1'b0;
         r_s_data  <= 8'd0;
         r_s_last  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Any low sample of Valid arms the next stream; a level held over
         // a reset or a finished stream therefore never retriggers.
         if (!dec_valid) begin
            r_armed <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (dec_valid && r_armed) begin
                  r_armed <= 1'b0;
                  r_w     <= '0;
                  r_p     <= 1'b0;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (RD_LAT == 0) begin
                  r_state <= ST_CAP;
               end else begin
                  r_wait  <= c_wait_init;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_wait == 2'd0) begin
                  r_state <= ST_CAP;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            ST_CAP: begin
               r_s_data  <= w_word[31:24];
               r_sh      <= {w_word[23:0], 8'h00};
               r_s_valid <= 1'b1;
               r_s_last  <= 1'b0;
               r_bcnt    <= 2'd0;
               r_state   <= ST_SEND;
            end
            ST_SEND: begin
               if (w_hs) begin
                  if (r_bcnt == 2'd3) begin
                     r_s_valid <= 1'b0;
                     r_s_last  <= 1'b0;
                     // Word boundaries drive the next address on the final
                     // handshake edge itself, so the read latency countdown
                     // starts immediately and the gap is RD_LAT+1 cycles.
                     if (!w_last_w) begin
                        r_w    <= r_w + 1'b1;
                        r_addr <= r_w + 1'b1;
                        if (RD_LAT == 0) begin
                           r_state <= ST_CAP;
                        end else begin
                           r_wait  <= c_wait_init;
                           r_state <= ST_WAIT;
                        end
                     end else if (c_r_en && !r_p) begin
                        r_p    <= 1'b1;
                        r_w    <= '0;
                        r_addr <= '0;
                        if (RD_LAT == 0) begin
                           r_state <= ST_CAP;
                        end else begin
                           r_wait  <= c_wait_init;
                           r_state <= ST_WAIT;
                        end
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                     end
                  end else begin
                     r_s_data <= r_sh[31:24];
                     r_sh     <= {r_sh[23:0], 8'h00};
                     r_bcnt   <= r_bcnt + 1'b1;
                     r_s_last <= (r_bcnt == 2'd2) & w_last_w & w_final_pass;
                  end
               end
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_addr = r_addr;
   assign s_valid  = r_s_valid;
   assign s_data   = r_s_data;
   assign s_last   = r_s_last;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decap_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decap_result_streamer
//  Purpose  : Self-checking bench. Three streamers (RD_LAT = 1, 0, 3) share
//             stimulus; each has its own core model, expectation queue and
//             monitor checking bytes, s_last, done, latency, gaps and holds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decap_result_streamer;

   localparam int WORDS = 8;
   localparam int AW    = 3;
`ifdef DECAP_STREAM_R_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        dec_valid;
   logic        s_ready;
   logic [31:0] k_base;
   bit          rnd_ready;
   int          tests     = 0;
   int          fails     = 0;
   int          cyc       = 0;
   int          starts    = 0;
   int          trig_cyc  = 0;

   always #5 Clk = ~Clk;

   // Cycle counter used for first-byte latency checks
   always @(posedge Clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

      logic [AW-1:0] addr;
      logic [31:0]   k;
      logic [31:0]   r;
      logic          sv;
      logic          sl;
      logic          bsy;
      logic          dn;
      logic [7:0]    sd;
      logic [AW-1:0] apipe [0:3];
      logic [AW-1:0] da;

      // Core model: read data follows the address after LAT clocks
      always @(posedge Clk) begin
         apipe[0] <= addr;
         for (int j = 1; j < 4; j++) apipe[j] <= apipe[j-1];
      end
      assign da = (LAT == 0) ? addr : apipe[(LAT == 0) ? 0 : LAT - 1];
      assign k  = k_base + 32'(da) * 32'h11111111;
      assign r  = 32'hA0000000 | 32'(da);

      decap_result_streamer #(.WORDS(WORDS), .AW(AW), .RD_LAT(LAT)) u_dut (
         .Clk      (Clk),
         .Reset_n  (Reset_n),
         .dec_valid(dec_valid),
         .out_addr (addr),
         .out_k    (k),
         .out_r    (r),
         .s_ready  (s_ready),
         .s_valid  (sv),
         .s_data   (sd),
         .s_last   (sl),
         .busy     (bsy),
         .done     (dn)
      );

      logic [8:0] q [$];
      int         pend = 0;
      int         cnt  = 0;
      int         low  = 0;
      int         seen = 0;
      bit         counting = 0;
      bit         first_pending = 0;
      bit         exp_done = 0;
      bit         hold = 0;
      logic [8:0] prev = 9'd0;

      // Scoreboard: expands each new stream into bytes, then checks the DUT
      always @(negedge Clk) begin : mon
         logic [8:0]  e;
         logic [31:0] word;
         if (!Reset_n) begin
            q.delete();
            pend = 0; cnt = 0; counting = 0; first_pending = 0;
            exp_done = 0; hold = 0; seen = starts;
         end else begin
            if (seen != starts) begin
               seen = starts; first_pending = 1; cnt = 0; counting = 0;
               for (int p = 0; p < NP; p++) begin
                  for (int w = 0; w < WORDS; w++) begin
                     word = (p == 0) ? k_base + 32'(w) * 32'h11111111 : (32'hA0000000 | 32'(w));
                     for (int b = 0; b < 4; b++)
                        q.push_back({(p == NP-1 && w == WORDS-1 && b == 3), 8'(word >> (24 - 8*b))});
                  end
               end
            end
            tests++;
            if (dn !== exp_done) begin
               fails++; $display("FAIL lat%0d done: got %b want %b", LAT, dn, exp_done);
            end
            exp_done = 0;
            if (hold) begin
               tests++;
               if (sv !== 1'b1 || {sl, sd} !== prev) begin
                  fails++; $display("FAIL lat%0d hold: got v=%b %h want v=1 %h", LAT, sv, {sl, sd}, prev);
               end
            end
            if (counting) begin
               if (sv) begin
                  tests++;
                  if (low != LAT + 1) begin
                     fails++; $display("FAIL lat%0d gap: got %0d want %0d", LAT, low, LAT + 1);
                  end
                  counting = 0;
               end else begin
                  low++;
               end
            end
            if (sv && first_pending) begin
               tests++;
               if (cyc != trig_cyc + LAT + 2) begin
                  fails++; $display("FAIL lat%0d first_latency: got %0d want %0d", LAT, cyc - trig_cyc, LAT + 2);
               end
               first_pending = 0;
            end
            if (sv && s_ready) begin
               tests++;
               if (q.size() == 0) begin
                  fails++; $display("FAIL lat%0d unexpected_byte: got %h want none", LAT, {sl, sd});
               end else begin
                  e = q.pop_front();
                  if ({sl, sd} !== e) begin
                     fails++; $display("FAIL lat%0d byte%0d: got last=%b %h want last=%b %h", LAT, cnt, sl, sd, e[8], e[7:0]);
                  end
                  cnt++;
                  if (cnt % 4 == 0) begin
                     if (e[8]) begin
                        exp_done = 1; cnt = 0;
                     end else begin
                        counting = 1; low = 0;
                     end
                  end
               end
            end
            hold = sv && !s_ready;
            prev = {sl, sd};
            pend = q.size();
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++; $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic cyc1();
      @(posedge Clk);
      #1;
      if (rnd_ready) s_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_stream();
      dec_valid = 1'b1;
      trig_cyc  = cyc + 1;
      starts++;
   endtask

   task automatic rearm();
      dec_valid = 1'b0;
      repeat (2) cyc1();
   endtask

   function automatic bit all_idle();
      return g_dut[0].pend == 0 && g_dut[1].pend == 0 && g_dut[2].pend == 0 &&
             !g_dut[0].bsy && !g_dut[1].bsy && !g_dut[2].bsy;
   endfunction

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin
         cyc1(); n++;
      end while (!all_idle() && n < 5000);
      tests++;
      if (!all_idle()) begin
         fails++; $display("FAIL %s timeout: got busy after %0d cycles want idle", nm, n);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_lat1"}, 32'({g_dut[0].addr, g_dut[0].sv, g_dut[0].sd, g_dut[0].sl, g_dut[0].bsy, g_dut[0].dn}), 32'd0);
      chk({nm, "_lat0"}, 32'({g_dut[1].addr, g_dut[1].sv, g_dut[1].sd, g_dut[1].sl, g_dut[1].bsy, g_dut[1].dn}), 32'd0);
      chk({nm, "_lat3"}, 32'({g_dut[2].addr, g_dut[2].sv, g_dut[2].sd, g_dut[2].sl, g_dut[2].bsy, g_dut[2].dn}), 32'd0);
   endtask

   task automatic wait_byte(input int idx, input string nm);
      int n = 0;
      while (!(g_dut[0].sv && g_dut[0].cnt == idx) && n < 500) begin
         cyc1(); n++;
      end
      chk(nm, 32'(n < 500), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      Reset_n = 1'b0; dec_valid = 1'b0; s_ready = 1'b1; rnd_ready = 0;
      k_base = 32'h01234567;
      repeat (3) cyc1();
      chk_zero("reset_state");
      Reset_n = 1'b1;
      repeat (3) cyc1();

      // Basic key stream, then Valid held high for 200 cycles
      start_stream();
      wait_idle("basic");
      nb = 0;
      repeat (200) begin
         cyc1();
         if (g_dut[0].bsy || g_dut[1].bsy || g_dut[2].bsy) nb++;
      end
      chk("level_hold_busy", 32'(nb), 32'd0);

      // Backpressure: stall 5 cycles while byte 6 is presented
      rearm();
      k_base = $urandom;
      start_stream();
      wait_byte(6, "bp_reach_byte6");
      s_ready = 1'b0;
      repeat (5) cyc1();
      s_ready = 1'b1;
      wait_idle("backpressure");

      // Reset during byte 10 with Valid held high; no restream until rearmed
      rearm();
      k_base = $urandom;
      start_stream();
      wait_byte(10, "rst_reach_byte10");
      #1 Reset_n = 1'b0;
      #1 chk_zero("async_reset");
      repeat (3) cyc1();
      Reset_n = 1'b1;
      repeat (40) cyc1();
      chk_zero("no_restream");
      rearm();
      start_stream();
      wait_idle("restart");

      // Randomized ready with random key bases
      rnd_ready = 1;
      repeat (4) begin
         rearm();
         k_base = $urandom;
         start_stream();
         wait_idle("random");
      end
      rnd_ready = 0;
      s_ready = 1'b1;
      repeat (5) cyc1();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
